// File: rtl/hall_pulse_filter_pkg.sv
// ----------------------------------------------------------------------------
// dcmctrl_pkg
// Shared types and constants for the Hall-sensor conditioning path.
//   hall_state_t              : per-channel debounce FSM state
//   HALL_DEBOUNCE_CYCLES_24M  : 10 us acceptance window at 24 MHz
//   N_CHANNELS_DEFAULT        : number of Hall inputs on the motor board
//   cnt_width()               : debounce counter width for a given window
// ----------------------------------------------------------------------------
package dcmctrl_pkg;

    localparam int HALL_DEBOUNCE_CYCLES_24M = 240;
    localparam int N_CHANNELS_DEFAULT       = 6;

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        CHK_HIGH = 2'd1,
        HIGH     = 2'd2,
        CHK_LOW  = 2'd3
    } hall_state_t;

    // The counter only ever reaches cycles-1, so this width leaves headroom.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/hall_pulse_filter_if.sv
// ----------------------------------------------------------------------------
// hall_pulse_filter_if
// Bundles the per-channel control and status lines of the Hall filter.
//   enable       : global run enable (low holds every channel idle)
//   hall_in      : raw asynchronous Hall inputs
//   glitch_clear : per-channel clear of glitch_flag
//   pulse_out    : debounced level to the motor controller
//   rise_strobe  : one-cycle strobe on each accepted 0->1
//   glitch_flag  : sticky rejected-transition flag
// master = driver side (controller/bench), slave = the filter itself.
// ----------------------------------------------------------------------------
interface hall_pulse_filter_if
    import dcmctrl_pkg::*;
#(
    parameter int N_CHANNELS = N_CHANNELS_DEFAULT
);
    logic                  enable;
    logic [N_CHANNELS-1:0] hall_in;
    logic [N_CHANNELS-1:0] glitch_clear;
    logic [N_CHANNELS-1:0] pulse_out;
    logic [N_CHANNELS-1:0] rise_strobe;
    logic [N_CHANNELS-1:0] glitch_flag;

    modport master (
        output enable, hall_in, glitch_clear,
        input  pulse_out, rise_strobe, glitch_flag
    );

    modport slave (
        input  enable, hall_in, glitch_clear,
        output pulse_out, rise_strobe, glitch_flag
    );

endinterface

// File: rtl/hall_pulse_filter_ch.sv
// ----------------------------------------------------------------------------
// hall_debounce_ch
// One Hall channel: two-flop synchroniser, debounce FSM with acceptance
// counter, registered level/strobe outputs and a sticky glitch flag.
//   i_clk, i_resetn  : clock, synchronous active-low reset
//   i_enable         : low forces the FSM idle (glitch flag is kept)
//   i_hall           : raw asynchronous input
//   i_glitch_clear   : clears o_glitch unless a glitch is set the same cycle
//   o_pulse          : debounced level
//   o_rise           : one-cycle strobe after acceptance into HIGH
//   o_glitch         : sticky rejected-transition flag
//
// state    | meaning
// ---------+-------------------------------------------------------
// LOW      | accepted level 0, waiting for s2 to go high
// CHK_HIGH | s2 high, counting towards acceptance of level 1
// HIGH     | accepted level 1, waiting for s2 to go low
// CHK_LOW  | s2 low, counting towards acceptance of level 0
// ----------------------------------------------------------------------------
module hall_debounce_ch
    import dcmctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = HALL_DEBOUNCE_CYCLES_24M
)(
    input  logic i_clk,
    input  logic i_resetn,
    input  logic i_enable,
    input  logic i_hall,
    input  logic i_glitch_clear,
    output logic o_pulse,
    output logic o_rise,
    output logic o_glitch
);
    localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    hall_state_t      r_state;
    hall_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_pulse;
    logic             w_pulse_nxt;
    logic             r_rise;
    logic             w_rise_nxt;
    logic             r_glitch;
    logic             w_glitch_set;

    // Synchroniser keeps sampling while disabled so re-enable sees a fresh s2.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_hall;
            r_s2 <= r_s1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_state  <= LOW;
            r_cnt    <= '0;
            r_pulse  <= 1'b0;
            r_rise   <= 1'b0;
            r_glitch <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_pulse  <= w_pulse_nxt;
            r_rise   <= w_rise_nxt;
            // A glitch detected in the same cycle as a clear must not be lost.
            r_glitch <= w_glitch_set | (r_glitch & ~i_glitch_clear);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_pulse_nxt  = r_pulse;
        w_rise_nxt   = 1'b0;
        w_glitch_set = 1'b0;

        if (!i_enable) begin
            w_state_nxt = LOW;
            w_cnt_nxt   = '0;
            w_pulse_nxt = 1'b0;
        end else begin
            case (r_state)
                LOW: begin
                    if (r_s2) begin
                        w_state_nxt = CHK_HIGH;
                        w_cnt_nxt   = '0;
                    end
                end
                CHK_HIGH: begin
                    if (!r_s2) begin
                        w_state_nxt  = LOW;
                        w_glitch_set = 1'b1;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nxt = HIGH;
                        w_pulse_nxt = 1'b1;
                        w_rise_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (!r_s2) begin
                        w_state_nxt = CHK_LOW;
                        w_cnt_nxt   = '0;
                    end
                end
                CHK_LOW: begin
                    if (r_s2) begin
                        w_state_nxt  = HIGH;
                        w_glitch_set = 1'b1;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nxt = LOW;
                        w_pulse_nxt = 1'b0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = LOW;
                    w_cnt_nxt   = '0;
                    w_pulse_nxt = 1'b0;
                end
            endcase
        end
    end

    assign o_pulse  = r_pulse;
    assign o_rise   = r_rise;
    assign o_glitch = r_glitch;

endmodule

// File: rtl/hall_pulse_filter.sv
// ----------------------------------------------------------------------------
// hall_pulse_filter
// Conditions N_CHANNELS raw Hall lines for the motor controller. Each channel
// is an independent hall_debounce_ch; nothing is shared between channels.
//   clk     : system clock (24 MHz)
//   resetn  : synchronous active-low reset
//   bus     : slave side of hall_pulse_filter_if (enable, hall_in,
//             glitch_clear in; pulse_out, rise_strobe, glitch_flag out)
// DEBOUNCE_CYCLES is legal in 1..65535.
// ----------------------------------------------------------------------------
module hall_pulse_filter
    import dcmctrl_pkg::*;
#(
    parameter int N_CHANNELS      = N_CHANNELS_DEFAULT,
    parameter int DEBOUNCE_CYCLES = HALL_DEBOUNCE_CYCLES_24M
)(
    input  logic                clk,
    input  logic                resetn,
    hall_pulse_filter_if.slave  bus
);

    for (genvar g = 0; g < N_CHANNELS; g++) begin : g_ch
        hall_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .i_clk          (clk),
            .i_resetn       (resetn),
            .i_enable       (bus.enable),
            .i_hall         (bus.hall_in[g]),
            .i_glitch_clear (bus.glitch_clear[g]),
            .o_pulse        (bus.pulse_out[g]),
            .o_rise         (bus.rise_strobe[g]),
            .o_glitch       (bus.glitch_flag[g])
        );
    end

endmodule

// File: tb/tb_hall_pulse_filter.sv
// ----------------------------------------------------------------------------
// tb_hall_pulse_filter
// Directed scenarios plus a randomized soak for hall_pulse_filter with
// DEBOUNCE_CYCLES=4, N_CHANNELS=6. A run-length reference model predicts the
// outputs every cycle: a level flips once the synchronised input has differed
// from it for DEBOUNCE_CYCLES+1 consecutive samples; an interrupted run is a
// glitch.
// ----------------------------------------------------------------------------
module tb_hall_pulse_filter;

    localparam int N = 6;
    localparam int D = 4;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    hall_pulse_filter_if #(.N_CHANNELS(N)) bus ();

    hall_pulse_filter #(
        .N_CHANNELS      (N),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    bit [N-1:0] m_s1;
    bit [N-1:0] m_s2;
    bit [N-1:0] m_level;
    bit [N-1:0] m_rise;
    bit [N-1:0] m_glitch;
    int         m_run [N];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model, advanced once per rising edge with the inputs the DUT sees.
    task automatic model_step();
        bit set;
        if (!resetn) begin
            m_s1 = '0; m_s2 = '0; m_level = '0; m_rise = '0; m_glitch = '0;
            for (int c = 0; c < N; c++) m_run[c] = 0;
        end else begin
            for (int c = 0; c < N; c++) begin
                set       = 1'b0;
                m_rise[c] = 1'b0;
                if (!bus.enable) begin
                    m_level[c] = 1'b0;
                    m_run[c]   = 0;
                end else if (m_s2[c] != m_level[c]) begin
                    m_run[c]++;
                    if (m_run[c] == D + 1) begin
                        m_level[c] = ~m_level[c];
                        m_run[c]   = 0;
                        m_rise[c]  = m_level[c];
                    end
                end else if (m_run[c] > 0) begin
                    set      = 1'b1;
                    m_run[c] = 0;
                end
                m_glitch[c] = set | (m_glitch[c] & ~bus.glitch_clear[c]);
            end
            m_s2 = m_s1;
            m_s1 = bus.hall_in;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_eq("pulse_out",   32'(bus.pulse_out),   32'(m_level));
        check_eq("rise_strobe", 32'(bus.rise_strobe), 32'(m_rise));
        check_eq("glitch_flag", 32'(bus.glitch_flag), 32'(m_glitch));
    endtask

    initial begin
        int got;
        int rises;
        int bad;
        int rem [N];

        resetn           = 1'b0;
        bus.enable       = 1'b1;
        bus.glitch_clear = '0;
        bus.hall_in      = N'($urandom);

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.hall_in = N'($urandom);
        end
        check_eq("rst_pulse",  32'(bus.pulse_out),   32'd0);
        check_eq("rst_rise",   32'(bus.rise_strobe), 32'd0);
        check_eq("rst_glitch", 32'(bus.glitch_flag), 32'd0);
        bus.hall_in = '0;
        resetn      = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check_eq("post_rst_pulse", 32'(bus.pulse_out), 32'd0);

        // Clean pulse on channel 2
        bus.hall_in[2] = 1'b1;
        got = -1; rises = 0; bad = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.rise_strobe[2]) rises++;
            if (got < 0 && bus.pulse_out[2]) got = i - 1;
            if ((bus.pulse_out & ~6'b000100) != 0) bad = 1;
        end
        check_eq("ch2_rise_latency", 32'(got), 32'(D + 2));
        check_eq("ch2_strobe_count", 32'(rises), 32'd1);
        bus.hall_in[2] = 1'b0;
        got = -1; rises = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.rise_strobe[2]) rises++;
            if (got < 0 && !bus.pulse_out[2]) got = i - 1;
            if ((bus.pulse_out & ~6'b000100) != 0) bad = 1;
        end
        check_eq("ch2_fall_latency", 32'(got), 32'(D + 2));
        check_eq("ch2_fall_no_strobe", 32'(rises), 32'd0);
        check_eq("ch2_others_quiet", 32'(bad), 32'd0);

        // Glitch on channel 0
        bus.hall_in[0] = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.pulse_out[0] || bus.rise_strobe[0]) bad = 1;
        end
        bus.hall_in[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.pulse_out[0] || bus.rise_strobe[0]) bad = 1;
        end
        check_eq("ch0_no_pulse", 32'(bad), 32'd0);
        check_eq("ch0_glitch_set", 32'(bus.glitch_flag[0]), 32'd1);
        for (int i = 0; i < 5; i++) tick();
        check_eq("ch0_glitch_sticky", 32'(bus.glitch_flag[0]), 32'd1);
        bus.glitch_clear[0] = 1'b1;
        tick();
        bus.glitch_clear[0] = 1'b0;
        check_eq("ch0_glitch_cleared", 32'(bus.glitch_flag[0]), 32'd0);

        // Bounce while high on channel 5
        bus.hall_in[5] = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check_eq("ch5_high", 32'(bus.pulse_out[5]), 32'd1);
        bus.hall_in[5] = 1'b0;
        tick(); tick();
        bus.hall_in[5] = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (!bus.pulse_out[5] || bus.rise_strobe[5]) bad = 1;
        end
        check_eq("ch5_held_no_strobe", 32'(bad), 32'd0);
        check_eq("ch5_glitch", 32'(bus.glitch_flag[5]), 32'd1);

        // Enable drop during CHK_HIGH on channel 1
        bus.hall_in[1] = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        bus.enable = 1'b0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.pulse_out[1] || bus.rise_strobe[1]) bad = 1;
        end
        check_eq("ch1_disabled_quiet", 32'(bad), 32'd0);
        check_eq("ch1_disabled_pulse", 32'(bus.pulse_out), 32'd0);
        check_eq("ch5_glitch_kept", 32'(bus.glitch_flag[5]), 32'd1);
        bus.enable = 1'b1;
        got = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (got < 0 && bus.rise_strobe[1]) got = i;
        end
        check_eq("ch1_reenable_latency", 32'(got), 32'(D + 1));
        bus.hall_in[1] = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        // Glitch set and clear in the same cycle on channel 3
        check_eq("ch3_glitch_idle", 32'(bus.glitch_flag[3]), 32'd0);
        bus.hall_in[3] = 1'b1;
        tick(); tick();
        bus.hall_in[3] = 1'b0;
        tick(); tick();
        bus.glitch_clear[3] = 1'b1;
        tick();
        bus.glitch_clear[3] = 1'b0;
        check_eq("ch3_set_beats_clear", 32'(bus.glitch_flag[3]), 32'd1);
        tick();

        // Randomized soak
        for (int c = 0; c < N; c++) rem[c] = $urandom_range(1, 9);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < N; c++) begin
                rem[c]--;
                if (rem[c] <= 0) begin
                    bus.hall_in[c] = ~bus.hall_in[c];
                    rem[c] = $urandom_range(1, 9);
                end
                bus.glitch_clear[c] = ($urandom_range(0, 7) == 0);
            end
            bus.enable = ($urandom_range(0, 39) != 0);
            resetn     = ($urandom_range(0, 199) != 0);
            tick();
        end
        resetn = 1'b1;
        bus.enable = 1'b1;
        bus.glitch_clear = '0;
        for (int i = 0; i < 5; i++) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hall_pulse_filter.md
# hall_pulse_filter

Per-channel Hall-sensor conditioning stage that sits directly upstream of the motor controller's `motor_pulse` input. Each raw Hall line is synchronised into `clk` and debounced with a four-state FSM. The block emits a clean level for the motor controller, a one-cycle rising-edge strobe, and a sticky glitch flag for diagnostics. Channels are independent and fully parallel; there is no time-multiplexing.

## Interface
- `N_CHANNELS`, 6 — number of Hall inputs.
- `DEBOUNCE_CYCLES`, 240 — cycles a new level must persist before acceptance (10 µs at 24 MHz). Legal range is 1..65535.
- `CNT_W`, derived as `$clog2(DEBOUNCE_CYCLES+1)` — debounce counter width.
- `clk`  in  1  — system clock (24 MHz).
- `resetn`  in  1  — synchronous, active-low reset.
- `enable`  in  1  — while low, all channels are held idle.
- `hall_in`  in  N_CHANNELS  — raw asynchronous Hall inputs.
- `glitch_clear`  in  N_CHANNELS  — per-channel clear of `glitch_flag`.
- `pulse_out`  out  N_CHANNELS  — debounced level; connects to the motor controller's `motor_pulse`.
- `rise_strobe`  out  N_CHANNELS  — one-cycle pulse when `pulse_out` goes 0→1.
- `glitch_flag`  out  N_CHANNELS  — sticky; set when a transition is rejected.

## Operation
- Synchroniser: two flops per channel, `s1` then `s2`. Both reset to 0.
- Per-channel FSM states: `LOW`, `CHK_HIGH`, `HIGH`, `CHK_LOW`.
- Reset: FSM goes to `LOW`, `cnt`=0, and all outputs are 0.
- `LOW`:
  - `s2`=1 → `CHK_HIGH`, `cnt`←0.
  - Otherwise stay.
- `CHK_HIGH`:
  - `s2`=0 → `LOW`, `glitch_flag`←1.
  - Else if `cnt`==DEBOUNCE_CYCLES-1 → `HIGH`, `pulse_out`←1, `rise_strobe`←1.
  - Else `cnt`←`cnt`+1.
- `HIGH`:
  - `s2`=0 → `CHK_LOW`, `cnt`←0.
- `CHK_LOW`:
  - `s2`=1 → `HIGH`, `glitch_flag`←1.
  - Else if `cnt`==DEBOUNCE_CYCLES-1 → `LOW`, `pulse_out`←0.
  - Else `cnt`←`cnt`+1.
- `pulse_out` changes only on the accepting transitions into `HIGH` and into `LOW`. It holds its value during the `CHK_*` states.
- `rise_strobe` is 0 in every cycle except the single cycle after acceptance into `HIGH`. Acceptance into `LOW` produces no strobe.
- `enable`=0 (evaluated each cycle, after `resetn`): FSM←`LOW`, `cnt`←0, `pulse_out`←0, `rise_strobe`←0.
  - `glitch_flag` is held, not cleared.
  - Synchroniser flops keep sampling.
- `glitch_flag` set and `glitch_clear` in the same cycle: set wins.
- `glitch_clear` with no set that cycle clears the flag the next cycle.
- The counter never wraps: it is bounded by the acceptance compare, and `CNT_W` covers DEBOUNCE_CYCLES.

## Timing
- `hall_in` is high, meeting setup, at edge E0:
  - `s1`=1 after E0, `s2`=1 after E1.
  - FSM enters `CHK_HIGH` at E2.
  - Acceptance happens at E2+DEBOUNCE_CYCLES.
  - `pulse_out` and `rise_strobe` are first high in the cycle after that edge.
- Total rising latency is DEBOUNCE_CYCLES+2 clock edges from E0. Falling latency is identical.
- Minimum accepted input pulse is DEBOUNCE_CYCLES+1 cycles, as seen at `s2`. Anything shorter is rejected and sets `glitch_flag`.
- `resetn` is asserted mid-check: the channel is in `LOW` with outputs 0 on the next cycle.
- After reset, a channel whose `hall_in` is stuck high produces one rise, DEBOUNCE_CYCLES+2 edges after the reset release edge.

## Structure
- Shared package `dcmctrl_pkg` holds:
  - the `hall_state_t` enum (`LOW`, `CHK_HIGH`, `HIGH`, `CHK_LOW`);
  - the default constants `HALL_DEBOUNCE_CYCLES_24M`=240 and `N_CHANNELS_DEFAULT`=6.
- Sub-module `hall_debounce_ch` contains the single-channel synchroniser, FSM, counter and flag.
- The top level is a generate loop over `N_CHANNELS` with no logic shared across channels.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and N_CHANNELS=6.
- Reset: hold `resetn`=0 for 3 cycles with random `hall_in` → all outputs 0 and all FSMs in `LOW`. After release with `hall_in`=0, outputs stay 0.
- Clean pulse on channel 2: `hall_in[2]` high for 20 cycles → `pulse_out[2]` rises exactly 6 edges after the first sampling edge. `rise_strobe[2]` is high for exactly 1 cycle. `pulse_out[2]` falls 6 edges after `hall_in[2]` falls. Other channels stay 0.
- Glitch on channel 0: `hall_in[0]` high for 3 cycles → no `pulse_out`/`rise_strobe`. `glitch_flag[0]`=1 and persists. `glitch_clear[0]` for 1 cycle → flag is 0 the next cycle.
- Bounce while high on channel 5: `pulse_out[5]`=1, then `hall_in[5]` low for 2 cycles → `pulse_out[5]` stays 1, no new `rise_strobe`, `glitch_flag[5]`=1.
- Enable drop: drop `enable` during `CHK_HIGH` on channel 1 → no rise, `pulse_out[1]`=0. Re-enable with `hall_in[1]` still high → rise 4 edges after re-enable + 1.
- Simultaneous set and clear: `glitch_clear[3]`=1 in the same cycle a glitch is detected on channel 3 → `glitch_flag[3]`=1.
